// File: rtl/vending_core_multi_if.sv
// Coin/select inputs and credit/dispense outputs of the multi-drink vending core.
interface vending_core_multi_if #(
    parameter int unsigned NUM_DRINKS = 2,
    parameter int unsigned CREDIT_W   = 5
);
    logic                  in1;
    logic                  in0_5;
    logic [NUM_DRINKS-1:0] sel;
    logic                  cancel;
    logic [CREDIT_W-1:0]   credit;
    logic [NUM_DRINKS-1:0] drink;
    logic                  change;
    logic                  coin_reject;
    logic                  busy;

    modport master (
        output in1, in0_5, sel, cancel,
        input  credit, drink, change, coin_reject, busy
    );

    modport slave (
        input  in1, in0_5, sel, cancel,
        output credit, drink, change, coin_reject, busy
    );
endinterface

// File: rtl/vending_core_multi.sv
// Multi-drink vending controller: half-yuan credit, per-drink prices,
// timed dispense strobe and pulsed change return.
module vending_core_multi #(
    parameter int unsigned NUM_DRINKS                     = 2,
    parameter int unsigned PRICE_W                        = 5,
    parameter logic [NUM_DRINKS*PRICE_W-1:0] PRICES       = {5'd5, 5'd3},
    parameter int unsigned CREDIT_MAX                     = 20,
    parameter int unsigned CREDIT_W                       = 5,
    parameter int unsigned DISP_CYCLES                    = 50000000,
    parameter int unsigned CHANGE_PULSE_CYCLES            = 12500000,
    parameter int unsigned TIMEOUT_CYCLES                 = 500000000
) (
    input logic                  clk_50MHz,
    input logic                  reset,
    vending_core_multi_if.slave  bus
);

    localparam int unsigned IN_W    = NUM_DRINKS + 3;
    localparam int unsigned CMP_W   = ((PRICE_W > CREDIT_W) ? PRICE_W : CREDIT_W) + 1;
    localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > DISP_CYCLES)
                                      ? ((TIMEOUT_CYCLES > CHANGE_PULSE_CYCLES) ? TIMEOUT_CYCLES : CHANGE_PULSE_CYCLES)
                                      : ((DISP_CYCLES > CHANGE_PULSE_CYCLES) ? DISP_CYCLES : CHANGE_PULSE_CYCLES);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    state_t                state_q, state_n;
    logic [CREDIT_W-1:0]   credit_q, credit_n;
    logic [TMR_W-1:0]      timer_q, timer_n;
    logic [NUM_DRINKS-1:0] drink_q, drink_n;
    logic                  change_q, change_n;
    logic                  reject_q, reject_n;
    logic                  busy_q, busy_n;

    logic [IN_W-1:0]       sync1_q, sync2_q, sync3_q;
    logic [IN_W-1:0]       evt;
    logic                  in1_evt, in05_evt, cancel_evt;
    logic [NUM_DRINKS-1:0] sel_evt;

    logic [CMP_W-1:0]      coin_val, coin_sum, price_c;
    logic                  coin_ok;

    // Two-stage synchronizer plus one delay stage for rising-edge detection
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= {bus.cancel, bus.sel, bus.in0_5, bus.in1};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign evt        = sync2_q & ~sync3_q;
    assign in1_evt    = evt[0];
    assign in05_evt   = evt[1];
    assign sel_evt    = evt[2 +: NUM_DRINKS];
    assign cancel_evt = evt[IN_W-1];

    assign coin_val = CMP_W'({in1_evt, 1'b0}) + CMP_W'(in05_evt);
    assign coin_sum = CMP_W'(credit_q) + coin_val;

    // Price of the selected drink; only meaningful when sel_evt is one-hot
    always_comb begin
        price_c = '0;
        for (int i = 0; i < NUM_DRINKS; i++) begin
            if (sel_evt[i]) price_c = CMP_W'(PRICES[i*PRICE_W +: PRICE_W]);
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            timer_q  <= '0;
            drink_q  <= '0;
            change_q <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            credit_q <= credit_n;
            timer_q  <= timer_n;
            drink_q  <= drink_n;
            change_q <= change_n;
            reject_q <= reject_n;
            busy_q   <= busy_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        credit_n = credit_q;
        timer_n  = timer_q;
        drink_n  = drink_q;
        change_n = change_q;
        reject_n = 1'b0;
        coin_ok  = 1'b0;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (state_q == ST_COLLECT) timer_n = timer_q + TMR_W'(1);
                if (coin_val != '0) begin
                    if (coin_sum <= CMP_W'(CREDIT_MAX)) begin
                        coin_ok  = 1'b1;
                        credit_n = CREDIT_W'(coin_sum);
                        state_n  = ST_COLLECT;
                        timer_n  = '0;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
                // Selection sees the credit that already includes this clock's coin
                if (state_q == ST_COLLECT) begin
                    if ($onehot(sel_evt) && (CMP_W'(credit_n) >= price_c)) begin
                        credit_n = CREDIT_W'(CMP_W'(credit_n) - price_c);
                        drink_n  = sel_evt;
                        timer_n  = '0;
                        state_n  = ST_DISPENSE;
                    end else if (cancel_evt ||
                                 (!coin_ok && timer_q == TMR_W'(TIMEOUT_CYCLES - 1))) begin
                        timer_n  = '0;
                        change_n = (credit_n != '0);
                        state_n  = ST_CHANGE;
                    end
                end
            end

            ST_DISPENSE: begin
                reject_n = (coin_val != '0);
                if (timer_q == TMR_W'(DISP_CYCLES - 1)) begin
                    drink_n = '0;
                    timer_n = '0;
                    if (credit_q != '0) begin
                        change_n = 1'b1;
                        state_n  = ST_CHANGE;
                    end else begin
                        state_n  = ST_IDLE;
                    end
                end else begin
                    timer_n = timer_q + TMR_W'(1);
                end
            end

            ST_CHANGE: begin
                reject_n = (coin_val != '0);
                if (timer_q == TMR_W'(CHANGE_PULSE_CYCLES - 1)) begin
                    timer_n = '0;
                    if (change_q) begin
                        change_n = 1'b0;
                        if (credit_q != '0) credit_n = credit_q - CREDIT_W'(1);
                    end else if (credit_q == '0) begin
                        state_n = ST_IDLE;
                    end else begin
                        change_n = 1'b1;
                    end
                end else begin
                    timer_n = timer_q + TMR_W'(1);
                end
            end

            default: state_n = ST_IDLE;
        endcase

        busy_n = (state_n == ST_DISPENSE) || (state_n == ST_CHANGE);
    end

    assign bus.credit      = credit_q;
    assign bus.drink       = drink_q;
    assign bus.change      = change_q;
    assign bus.coin_reject = reject_q;
    assign bus.busy        = busy_q;

endmodule
